// File: rtl/winner_scan_nxn_if.sv
// Move handshake and game status bundle for winner_scan_nxn.
interface winner_scan_nxn_if #(
  parameter int N = 3
);
  localparam int W = $clog2(N);

  logic         move_valid;
  logic         move_ready;
  logic [W-1:0] move_row;
  logic [W-1:0] move_col;
  logic [1:0]   move_player;
  logic         move_err;
  logic         busy;
  logic         done;
  logic         winner;
  logic [1:0]   who;
  logic         draw;
  logic         game_over;

  modport master (
    output move_valid, move_row, move_col, move_player,
    input  move_ready, move_err, busy, done, winner, who, draw, game_over
  );

  modport slave (
    input  move_valid, move_row, move_col, move_player,
    output move_ready, move_err, busy, done, winner, who, draw, game_over
  );
endinterface

// File: rtl/winner_scan_nxn.sv
// N x N board, K-in-a-row winner detector. Owns the board, validates moves,
// then walks the four lines through the placed cell one cell per clock.
module winner_scan_nxn #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  winner_scan_nxn_if.slave game
);
  localparam int W     = $clog2(N);
  localparam int CELLS = N * N;
  localparam int IW    = $clog2(CELLS);
  localparam int CW    = $clog2(CELLS + 1);
  localparam int STEPS = 2 * K - 1;
  localparam int SW    = $clog2(STEPS);
  localparam int RW    = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     board [CELLS];
  logic [1:0]     turn;
  logic [1:0]     mover;
  logic [CW-1:0]  count;
  logic [W-1:0]   prow, pcol;
  logic [1:0]     dir;
  logic [SW-1:0]  step;
  logic [RW-1:0]  run;
  logic           win;
  logic           err_q, winner_q, draw_q;
  logic [1:0]     who_q;

  logic           in_range, legal, accept, move_ready;
  logic [IW-1:0]  move_idx;
  logic           on_board, scan_hit, last_step, win_nxt;
  logic [IW-1:0]  scan_idx;
  logic [RW-1:0]  run_nxt;

  assign move_ready = (state == IDLE) && !(winner_q || draw_q);
  assign accept     = game.move_valid && move_ready && legal && !clear;

  // Legality of the offered move against the current board and turn.
  always_comb begin
    in_range = (int'(game.move_row) < N) && (int'(game.move_col) < N);
    move_idx = '0;
    if (in_range) move_idx = IW'(int'(game.move_row) * N + int'(game.move_col));
    legal = in_range && (board[move_idx] == 2'b00) &&
            ((game.move_player == 2'b01) || (game.move_player == 2'b10)) &&
            (game.move_player == turn);
  end

  // Current scan cell: offset -(K-1)..+(K-1) along the active direction.
  always_comb begin
    int dr, dc, off, r, c;
    case (dir)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    off      = int'(step) - (K - 1);
    r        = int'(prow) + dr * off;
    c        = int'(pcol) + dc * off;
    on_board = (r >= 0) && (r < N) && (c >= 0) && (c < N);
    scan_idx = '0;
    if (on_board) scan_idx = IW'(r * N + c);
    scan_hit = on_board && (board[scan_idx] == mover);
    // Step 0 of every direction starts from an empty run.
    run_nxt = '0;
    if (scan_hit) begin
      if (step == '0)            run_nxt = RW'(1);
      else if (run == RW'(K))    run_nxt = run;
      else                       run_nxt = run + 1'b1;
    end
    win_nxt   = win || (run_nxt == RW'(K));
    last_step = (dir == 2'd3) && (step == SW'(STEPS - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; clear returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (last_step) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Board, turn, scan datapath and sticky result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CELLS; i++) board[i] <= '0;
      turn <= 2'b01; mover <= '0; count <= '0; prow <= '0; pcol <= '0;
      dir <= '0; step <= '0; run <= '0; win <= 1'b0;
      err_q <= 1'b0; winner_q <= 1'b0; draw_q <= 1'b0; who_q <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < CELLS; i++) board[i] <= '0;
      turn <= 2'b01; mover <= '0; count <= '0; prow <= '0; pcol <= '0;
      dir <= '0; step <= '0; run <= '0; win <= 1'b0;
      err_q <= 1'b0; winner_q <= 1'b0; draw_q <= 1'b0; who_q <= '0;
    end else begin
      err_q <= game.move_valid && move_ready && !legal;
      case (state)
        IDLE: if (accept) begin
          board[move_idx] <= game.move_player;
          count <= count + 1'b1;
          turn  <= ~turn;
          mover <= game.move_player;
          prow  <= game.move_row;
          pcol  <= game.move_col;
          dir   <= '0;
          step  <= '0;
          run   <= '0;
          win   <= 1'b0;
        end
        SCAN: begin
          run <= run_nxt;
          win <= win_nxt;
          if (step == SW'(STEPS - 1)) begin
            step <= '0;
            dir  <= dir + 1'b1;
          end else begin
            step <= step + 1'b1;
          end
          // Result flags land on the same edge that enters DONE.
          if (last_step) begin
            if (win_nxt) begin
              winner_q <= 1'b1;
              who_q    <= mover;
            end else if (count == CW'(CELLS)) begin
              draw_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign game.move_ready = move_ready;
  assign game.move_err   = err_q;
  assign game.busy       = (state == SCAN);
  assign game.done       = (state == DONE);
  assign game.winner     = winner_q;
  assign game.who        = who_q;
  assign game.draw       = draw_q;
  assign game.game_over  = winner_q || draw_q;
endmodule

// File: doc/winner_scan_nxn.md
# winner_scan_nxn

Sequential winner detector for an N×N board game with a K-in-a-row win rule, generalising the fixed 3-cell combinational line check. It owns the board state, accepts one move per handshake, and validates legality and turn order. After each legal move it scans the four lines through the new cell serially, one cell per clock. It sits between the move-entry/controller logic and the display and score logic.

## Interface
- N, 3, board side length (3..8)
- K, 3, run length needed to win (2..N)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous new-game request; has priority over everything except reset
- move_valid  in  1  move offered
- move_ready  out  1  block can accept a move (high only in IDLE and not game_over)
- move_row  in  $clog2(N)  row index
- move_col  in  $clog2(N)  column index
- move_player  in  2  01 = X, 10 = O; 00 and 11 are illegal
- move_err  out  1  one-cycle pulse: offered move rejected
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse: evaluation of last legal move finished
- winner  out  1  sticky: a player has K in a row
- who  out  2  sticky winner code (01/10), 00 when no winner
- draw  out  1  sticky: board full, no winner
- game_over  out  1  winner | draw

## Operation
- Cell encoding: 00 empty, 01 X, 10 O; board stored as N*N 2-bit registers, row-major.
- Turn register: X moves first, then alternates on each legal move only.
- Acceptance happens in a cycle with move_valid & move_ready.
- Illegal move conditions:
  - row ≥ N or col ≥ N;
  - target cell not empty;
  - move_player not 01/10;
  - move_player ≠ current turn.
- Illegal move: move_err high next cycle; board, turn, count and flags are unchanged; the FSM stays in IDLE.
- Legal move: the cell is written, move_count increments, the turn toggles, and the FSM enters SCAN.
- FSM states: IDLE → SCAN → DONE → IDLE.
- SCAN visits four directions in fixed order: row (0,+1), column (+1,0), diagonal (+1,+1), anti-diagonal (+1,−1).
- Each direction takes 2K−1 steps, at offsets −(K−1)..+(K−1) from the placed cell.
- Per step, a run counter increments if the cell is on-board and equals the mover's code; otherwise it resets to 0.
- Off-board cells always break the run; there is no wrap across rows or columns.
- The run counter resets at the start of each direction.
- If the run counter reaches K at any step, a win flag is set. Scanning continues to the end, so latency is fixed.
- DONE (one cycle):
  - done=1;
  - if the win flag is set: winner=1, who=mover;
  - else if move_count==N*N: draw=1.
- winner, who and draw hold until clear or reset. With game_over=1, move_ready=0.
- clear (any state, including mid-SCAN):
  - next cycle the board is all empty, the turn is X, the count is 0, all flags are 0 and the FSM is in IDLE;
  - any move offered in the same cycle is ignored, with no move_err;
  - a pending done is suppressed.
- Reset has the same effect as clear, asynchronously.

## Timing
- Reset values: move_ready=1, move_err=0, busy=0, done=0, winner=0, who=00, draw=0, game_over=0.
- Move accepted at edge T. The cell is visible internally after T.
- busy is high for cycles T+1..T+4(2K−1).
- done is high at cycle T+4(2K−1)+1; winner, who and draw update at the same edge.
- Latency for N=K=3: done 21 cycles after acceptance.
- move_ready returns high the cycle after done, unless game_over.
- move_err is registered: it pulses the cycle after a rejected offer. move_ready stays high, so back-to-back offers are allowed.
- Throughput: one legal move per 4(2K−1)+2 cycles.

## Test plan
- N=3,K=3: X(0,0) O(1,0) X(0,1) O(1,1) X(0,2) → done 21 cycles after last accept; winner=1, who=01, draw=0; move_ready=0 afterwards.
- N=3,K=3: anti-diagonal win for O at (0,2),(1,1),(2,0) with X elsewhere non-winning → who=10.
- Occupied cell, wrong turn, player=11, and row=3 (with a 2-bit index) each give move_err one-cycle pulse; board unchanged; next legal X move accepted.
- Full 9-move draw sequence X(0,0) O(0,1) X(0,2) O(1,1) X(1,0) O(1,2) X(2,1) O(2,0) X(2,2) → draw=1, winner=0, who=00 on the 9th done.
- clear asserted at the 5th scan cycle → no done pulse; all flags 0, busy=0 next cycle; X move accepted after.
- N=5,K=4: X at (0,3),(0,4),(1,0),(1,1) with O interleaved non-winning → no win (no row wrap); then X (1,2),(1,3) completes (1,0..3) → winner=1 on that done; asynchronous rst_n mid-scan → all outputs return to reset values immediately.
